// File: rtl/csync_window_ctrl.sv
// Composite-sync separator and 240x240 window scheduler with lock FSM.
// Optional CSYNC_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module csync_window_ctrl #(
  parameter int C_HSYNC_MIN = 64,
  parameter int C_VSYNC_MIN = 1024,
  parameter int C_H_START   = 72,
  parameter int C_V_START   = 56,
  parameter int C_W         = 240,
  parameter int C_H         = 240,
  parameter int C_LINES_MIN = 250,
  parameter int C_LINES_MAX = 320,
  parameter int C_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_pixel_ena,
  input  logic       csync,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       locked
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [10:0] HMIN_W  = 11'(C_HSYNC_MIN);
  localparam logic [10:0] VMIN_W  = 11'(C_VSYNC_MIN);
  localparam logic [15:0] TMO_W   = 16'(C_TIMEOUT);
  localparam logic [9:0]  HS_W    = 10'(C_H_START);
  localparam logic [9:0]  HE_W    = 10'(C_H_START + C_W);
  localparam logic [9:0]  VS_W    = 10'(C_V_START);
  localparam logic [9:0]  VE_W    = 10'(C_V_START + C_H);
  localparam logic [9:0]  LMIN_W  = 10'(C_LINES_MIN);
  localparam logic [9:0]  LMAX_W  = 10'(C_LINES_MAX);

  lock_state_t state, state_nxt;

  logic [1:0]  sync_ff;
  logic        cs, cs_d;
  logic        rise, fall;
  logic [10:0] width;
  logic        armed;
  logic [15:0] wd;
  logic        timeout;
  logic        line_end, frame_end;
  logic [8:0]  frame_lines, frame_lines_nxt;
  logic        frame_ok;
  logic        in_x, in_y;

  // Synchronizer resets high so a pulse already in progress at reset release
  // never produces a rising edge; only a fresh rise arms the width counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 2'b11;
      cs_d    <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[0], csync};
      cs_d    <= cs;
    end
  end

`ifdef CSYNC_GLITCH_FILTER_EN
  logic [1:0] samp;
  logic       vote;

  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= 2'b11;
      vote <= 1'b1;
    end else begin
      samp <= {samp[0], sync_ff[1]};
      vote <= (sync_ff[1] & samp[0]) | (sync_ff[1] & samp[1]) | (samp[0] & samp[1]);
    end
  end

  assign cs = vote;
`else
  assign cs = sync_ff[1];
`endif

  assign rise      = cs & ~cs_d;
  assign fall      = ~cs & cs_d;
  assign timeout   = (wd == TMO_W);
  assign line_end  = fall & armed & (width >= HMIN_W) & (width < VMIN_W);
  assign frame_end = fall & armed & (width >= VMIN_W);

  // width holds the number of cycles the conditioned sync has been high
  always_ff @(posedge clk) begin
    if (reset) begin
      width <= '0;
      armed <= 1'b0;
    end else if (rise) begin
      width <= 11'd1;
      armed <= 1'b1;
    end else begin
      if (fall) armed <= 1'b0;
      if (cs && armed && width != 11'h7FF) width <= width + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (fall) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (cs && armed) begin
      if (width >= HMIN_W) hsync <= 1'b0;
      if (width >= VMIN_W) vsync <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd <= '0;
    end else if (rise || fall) begin
      wd <= '0;
    end else if (!timeout) begin
      wd <= wd + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (line_end || frame_end) x <= '0;
      else if (clk_pixel_ena && x != 9'd511) x <= x + 9'd1;

      if (timeout || frame_end) y <= '0;
      else if (line_end && y != 9'd511) y <= y + 9'd1;
    end
  end

  // The FSM judges the line count as it is being captured at the vsync end.
  assign frame_lines_nxt = frame_end ? y : frame_lines;
  assign frame_ok = ({1'b0, frame_lines_nxt} >= LMIN_W) && ({1'b0, frame_lines_nxt} <= LMAX_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNLOCKED;
      frame_lines <= '0;
    end else begin
      state       <= state_nxt;
      frame_lines <= frame_lines_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      case (state)
        UNLOCKED: state_nxt = frame_ok ? CHECK : UNLOCKED;
        CHECK:    state_nxt = frame_ok ? LOCKED : UNLOCKED;
        LOCKED:   state_nxt = frame_ok ? LOCKED : UNLOCKED;
        default:  state_nxt = UNLOCKED;
      endcase
    end
    if (timeout) state_nxt = UNLOCKED;
  end

  assign locked = (state == LOCKED);

  assign in_x = ({1'b0, x} >= HS_W) && ({1'b0, x} < HE_W);
  assign in_y = ({1'b0, y} >= VS_W) && ({1'b0, y} < VE_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      blank <= 1'b1;
    end else begin
      blank <= !((state == LOCKED) && in_x && in_y);
    end
  end

endmodule

// File: tb/tb_csync_window_ctrl.sv
// Bench for csync_window_ctrl: scaled timing parameters, randomized pulse trains,
// event-scheduled reference model; honours CSYNC_GLITCH_FILTER_EN when defined.
module tb_csync_window_ctrl;

  localparam int HMIN = 8;
  localparam int VMIN = 40;
  localparam int HST  = 6;
  localparam int VST  = 2;
  localparam int WW   = 10;
  localparam int HH   = 5;
  localparam int LMIN = 8;
  localparam int LMAX = 12;
  localparam int TMO  = 400;
`ifdef CSYNC_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_pixel_ena;
  logic       csync;
  logic       hsync, vsync, blank, locked;
  logic [8:0] x, y;

  // clock / reset
  always #4 clk = ~clk;

  csync_window_ctrl #(
    .C_HSYNC_MIN(HMIN), .C_VSYNC_MIN(VMIN), .C_H_START(HST), .C_V_START(VST),
    .C_W(WW), .C_H(HH), .C_LINES_MIN(LMIN), .C_LINES_MAX(LMAX), .C_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .clk_pixel_ena(clk_pixel_ena), .csync(csync),
    .hsync(hsync), .vsync(vsync), .blank(blank), .x(x), .y(y), .locked(locked)
  );

  // reference model: events scheduled at the cycle their effect becomes visible
  typedef enum int {EV_EDGE, EV_HS_LOW, EV_VS_LOW, EV_END_HI, EV_LINE, EV_FRAME} ev_kind_t;
  typedef struct {
    int       t;
    ev_kind_t k;
  } ev_t;

  ev_t ev_q[$];
  int  cyc;
  int  last_edge;
  int  x_m, y_m, good_run;
  bit  hs_m, vs_m, blank_m;
  int  n_checks, n_fail;

  task automatic sched(input int t, input ev_kind_t k);
    ev_t e;
    e.t = t;
    e.k = k;
    ev_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input logic en);
    bit tmo, ln, fr, plock;
    int px, py;
    px    = x_m;
    py    = y_m;
    plock = (good_run == 2);
    tmo   = ((cyc - 1) - last_edge) >= TMO;
    ln    = 1'b0;
    fr    = 1'b0;
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].t == cyc) begin
        case (ev_q[i].k)
          EV_EDGE:   last_edge = cyc;
          EV_HS_LOW: hs_m = 1'b0;
          EV_VS_LOW: vs_m = 1'b0;
          EV_END_HI: begin hs_m = 1'b1; vs_m = 1'b1; end
          EV_LINE:   ln = 1'b1;
          EV_FRAME:  fr = 1'b1;
          default:   ;
        endcase
        ev_q.delete(i);
      end
    end
    if (ln || fr) x_m = 0;
    else if (en && x_m < 511) x_m++;
    if (fr) begin
      if (py >= LMIN && py <= LMAX) good_run = (good_run < 2) ? good_run + 1 : 2;
      else good_run = 0;
      y_m = 0;
    end else if (ln && y_m < 511) begin
      y_m++;
    end
    if (tmo) begin
      good_run = 0;
      y_m      = 0;
    end
    blank_m = !(plock && px >= HST && px < HST + WW && py >= VST && py < VST + HH);
  endtask

  // driver: one clock cycle with the given inputs, then full output comparison
  task automatic step(input logic cs, input logic en);
    csync         = cs;
    clk_pixel_ena = en;
    @(posedge clk);
    cyc++;
    model_step(en);
    @(negedge clk);
    check("hsync", hsync, hs_m);
    check("vsync", vsync, vs_m);
    check("x", x, x_m);
    check("y", y, y_m);
    check("locked", locked, (good_run == 2));
    check("blank", blank, blank_m);
  endtask

  function automatic logic rnd_ena(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic pulse(input int w, input int gap, input int ena_pct);
    int t0;
    t0 = cyc;
    if (!(FILT && w == 1)) begin
      sched(t0 + LAT, EV_EDGE);
      sched(t0 + w + LAT, EV_EDGE);
      sched(t0 + w + LAT, EV_END_HI);
      if (w > HMIN) sched(t0 + LAT + HMIN, EV_HS_LOW);
      if (w > VMIN) sched(t0 + LAT + VMIN, EV_VS_LOW);
      if (w >= VMIN) sched(t0 + w + LAT, EV_FRAME);
      else if (w >= HMIN) sched(t0 + w + LAT, EV_LINE);
    end
    for (int i = 0; i < w; i++) step(1'b1, rnd_ena(ena_pct));
    for (int i = 0; i < gap; i++) step(1'b0, rnd_ena(ena_pct));
  endtask

  task automatic frame(input int lines);
    for (int i = 0; i < lines; i++) pulse(12, $urandom_range(28, 18), 60);
    pulse(50, 30, 60);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset = 1'b1;
    csync = 1'b1;
    clk_pixel_ena = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_blank", blank, 1'b1);
    check("rst_locked", locked, 1'b0);
    check("rst_x", x, 9'd0);
    check("rst_y", y, 9'd0);

    x_m = 0; y_m = 0; good_run = 0;
    hs_m = 1'b1; vs_m = 1'b1; blank_m = 1'b1;
    last_edge = 0;
    reset = 1'b0;

    // pulse in progress across reset: no fresh rise, so it must be discarded
    repeat (60) step(1'b1, 1'b1);
    sched(cyc + LAT, EV_EDGE);
    repeat (40) step(1'b0, 1'b1);

    // classification, rejection, pixel strobe colliding with pulse end
    pulse(30, 40, 50);
    pulse(5, 40, 50);
    pulse(30, 40, 100);

    // lock acquisition then a few locked frames
    frame(8);
    for (int f = 0; f < 4; f++) frame($urandom_range(LMAX, LMIN));

    // short frame drops lock, then reacquire
    frame(6);
    for (int f = 0; f < 3; f++) frame($urandom_range(LMAX, LMIN));

    // watchdog: long idle while locked; x saturates meanwhile
    repeat (600) step(1'b0, 1'b1);
    pulse(12, 25, 60);

    // single-cycle glitches
    repeat (5) pulse(1, 99, 50);
    for (int f = 0; f < 3; f++) frame($urandom_range(LMAX, LMIN));

    // y saturation followed by an over-long frame
    repeat (515) pulse(10, 8, 30);
    pulse(50, 30, 50);
    pulse(12, 25, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
